// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared CPU definitions: run-mode encodings and the board defaults
// for the CPU clock controller.
package cpu_clock_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_HALT = 2'b00,
      MODE_RUN  = 2'b01,
      MODE_STEP = 2'b10
   } mode_e;

   localparam int DEFAULT_DIV_C     = 5000000;
   localparam int DEBOUNCE_CYCLES_C = 270000;

   // The spare encoding 2'b11 is treated as HALT.
   function automatic mode_e decode_mode(input logic [1:0] m);
      case (m)
         2'b01:   return MODE_RUN;
         2'b10:   return MODE_STEP;
         default: return MODE_HALT;
      endcase
   endfunction

endpackage

// File: rtl/cpu_clock_ctrl_debounce.sv
// Step-button conditioner: two-flop synchroniser followed by a run-length
// debouncer with a registered level output (button is active-low).
module debounce
   import cpu_clock_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_C
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_db,
   output logic btn_armed
);

   localparam int RUN_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]       sync_q, sync_d;
   logic             samp_q, samp_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             db_q, db_d;
   logic             armed_q, armed_d;
   logic             s;

   assign s = sync_q[1];

   always_comb begin
      sync_d  = {sync_q[0], btn_raw};
      samp_d  = s;
      run_d   = run_q;
      db_d    = db_q;
      armed_d = armed_q;
      if (s != samp_q) begin
         run_d = RUN_W'(1);
      end else if (run_q < RUN_W'(DEBOUNCE_CYCLES)) begin
         run_d = run_q + RUN_W'(1);
      end
      // Presses are only trusted once a full released run has been seen since reset,
      // so a button held through reset cannot produce a press on release of reset.
      if (run_d == RUN_W'(DEBOUNCE_CYCLES)) begin
         db_d = s;
         if (s) armed_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q  <= 2'b11;
         samp_q  <= 1'b1;
         run_q   <= '0;
         db_q    <= 1'b1;
         armed_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         samp_q  <= samp_d;
         run_q   <= run_d;
         db_q    <= db_d;
         armed_q <= armed_d;
      end
   end

   assign btn_db    = db_q;
   assign btn_armed = armed_q;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable generator: one-cycle tick pulses from a programmable
// divider in RUN, or one per debounced button press in STEP.
module cpu_clock_ctrl
   import cpu_clock_ctrl_pkg::*;
#(
   parameter int DIV_WIDTH       = 24,
   parameter int DEFAULT_DIV     = DEFAULT_DIV_C,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_C,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [1:0]           mode,
   input  logic                 div_load,
   input  logic [DIV_WIDTH-1:0] div_value,
   input  logic                 step_btn,
   output logic                 tick,
   output logic [CNT_WIDTH-1:0] tick_count,
   output logic [DIV_WIDTH-1:0] div_cur
);

   mode_e                mode_q, mode_d, mode_in;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] div_eff;
   logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;
   logic                 db_prev_q, db_prev_d;
   logic                 step_pend_q, step_pend_d;
   logic                 btn_db, btn_armed;
   logic                 run_act, step_act, run_tick, press;

   debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .btn_raw  (step_btn),
      .btn_db   (btn_db),
      .btn_armed(btn_armed)
   );

   assign mode_in  = decode_mode(mode);
   assign div_eff  = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
   assign run_act  = enable && (mode_q == MODE_RUN);
   assign step_act = enable && (mode_q == MODE_STEP);
   assign run_tick = run_act && (cnt_q == div_eff - DIV_WIDTH'(1));
   assign press    = db_prev_q && !btn_db && btn_armed;
   // Gating with reset aborts a terminal count that coincides with reset.
   assign tick     = reset && (run_tick || (step_pend_q && step_act));

   always_comb begin
      mode_d      = mode_in;
      div_d       = div_load ? div_value : div_q;
      db_prev_d   = btn_db;
      step_pend_d = press && step_act;
      tcnt_d      = tcnt_q;
      cnt_d       = cnt_q;
      if (div_load || (mode_in != mode_q) || !run_act || run_tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + DIV_WIDTH'(1);
      end
      if (tick) tcnt_d = tcnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mode_q      <= MODE_HALT;
         div_q       <= DIV_WIDTH'(DEFAULT_DIV);
         cnt_q       <= '0;
         tcnt_q      <= '0;
         db_prev_q   <= 1'b1;
         step_pend_q <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         tcnt_q      <= tcnt_d;
         db_prev_q   <= db_prev_d;
         step_pend_q <= step_pend_d;
      end
   end

   assign tick_count = tcnt_q;
   assign div_cur    = div_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Self-checking bench for cpu_clock_ctrl: directed scenarios plus randomized
// RUN traffic against a timestamp-based reference model.
module tb_cpu_clock_ctrl;
   import cpu_clock_ctrl_pkg::*;

   localparam int DW   = 24;
   localparam int CW   = 32;
   localparam int DDIV = 5000000;
   localparam int DBC  = 8;

   logic          clk = 1'b0;
   logic          reset, enable, div_load, step_btn;
   logic [1:0]    mode;
   logic [DW-1:0] div_value;
   logic          tick;
   logic [CW-1:0] tick_count;
   logic [DW-1:0] div_cur;

   always #5 clk = ~clk;

   cpu_clock_ctrl #(
      .DIV_WIDTH      (DW),
      .DEFAULT_DIV    (DDIV),
      .DEBOUNCE_CYCLES(DBC),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .mode      (mode),
      .div_load  (div_load),
      .div_value (div_value),
      .step_btn  (step_btn),
      .tick      (tick),
      .tick_count(tick_count),
      .div_cur   (div_cur)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: RUN ticks fall on cycles where (cycle - start) mod D == D-1,
   // with start moved to the next cycle by every clear event.
   longint        cyc     = 0;
   longint        m_start = 0;
   logic [DW-1:0] m_div   = DW'(DDIV);
   int            m_mode  = 0;
   logic [CW-1:0] m_cnt   = '0;
   logic          exp_tick, obs_tick;
   int            win_ticks = 0;

   localparam logic [1:0] M_HALT = 2'b00, M_RUN = 2'b01, M_STEP = 2'b10, M_HALT2 = 2'b11;

   function automatic int norm(input logic [1:0] m);
      return (m == 2'b11) ? 0 : int'(m);
   endfunction

   function automatic longint eff_div();
      return (m_div == '0) ? 64'd1 : longint'(m_div);
   endfunction

   function automatic logic model_tc();
      longint d;
      d = eff_div();
      return (m_mode == 1) && (((cyc - m_start) % d) == d - 1);
   endfunction

   task automatic drive_cycle(input logic rst, input logic en, input logic [1:0] md,
                              input logic ld, input logic [DW-1:0] val, input logic btn);
      longint d;
      reset = rst; enable = en; mode = md; div_load = ld; div_value = val; step_btn = btn;
      @(negedge clk);
      d        = eff_div();
      exp_tick = rst && en && (m_mode == 1) && (((cyc - m_start) % d) == d - 1);
      obs_tick = tick;
      if (tick === 1'b1) win_ticks++;
      @(posedge clk);
      #1;
      if (exp_tick) m_cnt = m_cnt + 1'b1;
      if (!rst) begin
         m_mode = 0; m_div = DW'(DDIV); m_start = cyc + 1; m_cnt = '0;
      end else begin
         if (!(en && m_mode == 1)) m_start = cyc + 1;
         if (ld) begin m_div = val; m_start = cyc + 1; end
         if (norm(md) != m_mode) begin m_mode = norm(md); m_start = cyc + 1; end
      end
      cyc++;
   endtask

   task automatic run_n(input logic en, input logic [1:0] md, input logic btn, input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b1, en, md, 1'b0, '0, btn);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, M_HALT, 1'b0, '0, 1'b1);
      n_checks++;
      if (obs_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", obs_tick); end
      n_checks++;
      if (tick_count !== '0) begin n_fail++; $display("FAIL reset_tick_count: got %0d expected 0", tick_count); end
      n_checks++;
      if (div_cur !== DW'(DDIV)) begin n_fail++; $display("FAIL reset_div_cur: got %0d expected %0d", div_cur, DDIV); end
      win_ticks = 0;
      run_n(1'b1, M_HALT, 1'b1, 14);
      n_checks++;
      if (win_ticks != 0) begin n_fail++; $display("FAIL halt_no_tick: got %0d ticks expected 0", win_ticks); end
   endtask

   task automatic test_run_div4();
      logic [CW-1:0] base;
      run_n(1'b1, M_RUN, 1'b1, 2);
      drive_cycle(1'b1, 1'b1, M_RUN, 1'b1, DW'(4), 1'b1);
      base = tick_count;
      for (int k = 1; k <= 12; k++) begin
         drive_cycle(1'b1, 1'b1, M_RUN, 1'b0, '0, 1'b1);
         n_checks++;
         if (obs_tick !== ((k % 4) == 0)) begin
            n_fail++; $display("FAIL div4_tick cycle %0d: got %b expected %b", k, obs_tick, (k % 4) == 0);
         end
      end
      n_checks++;
      if (tick_count - base !== CW'(3)) begin
         n_fail++; $display("FAIL div4_count: got %0d expected 3", tick_count - base);
      end
   endtask

   task automatic test_div_zero();
      logic [CW-1:0] base;
      drive_cycle(1'b1, 1'b1, M_RUN, 1'b1, '0, 1'b1);
      base = tick_count;
      for (int k = 1; k <= 10; k++) begin
         drive_cycle(1'b1, 1'b1, M_RUN, 1'b0, '0, 1'b1);
         n_checks++;
         if (obs_tick !== 1'b1) begin n_fail++; $display("FAIL div0_tick cycle %0d: got %b expected 1", k, obs_tick); end
      end
      n_checks++;
      if (tick_count - base !== CW'(10)) begin
         n_fail++; $display("FAIL div0_count: got %0d expected 10", tick_count - base);
      end
      n_checks++;
      if (div_cur !== '0) begin n_fail++; $display("FAIL div0_div_cur: got %0d expected 0", div_cur); end
   endtask

   task automatic test_enable_drop();
      drive_cycle(1'b1, 1'b1, M_RUN, 1'b1, DW'(5), 1'b1);
      run_n(1'b1, M_RUN, 1'b1, 3);
      win_ticks = 0;
      run_n(1'b0, M_RUN, 1'b1, 20);
      n_checks++;
      if (win_ticks != 0) begin n_fail++; $display("FAIL en_low_ticks: got %0d expected 0", win_ticks); end
      for (int k = 1; k <= 5; k++) begin
         drive_cycle(1'b1, 1'b1, M_RUN, 1'b0, '0, 1'b1);
         n_checks++;
         if (obs_tick !== (k == 5)) begin
            n_fail++; $display("FAIL en_rise_tick cycle %0d: got %b expected %b", k, obs_tick, k == 5);
         end
      end
   endtask

   task automatic test_load_on_tc();
      int guard = 0;
      while (!model_tc() && guard < 20) begin
         drive_cycle(1'b1, 1'b1, M_RUN, 1'b0, '0, 1'b1);
         guard++;
      end
      n_checks++;
      if (guard >= 20) begin n_fail++; $display("FAIL tc_search: got no terminal count expected one within 20"); end
      drive_cycle(1'b1, 1'b1, M_RUN, 1'b1, DW'(2), 1'b1);
      n_checks++;
      if (obs_tick !== 1'b1) begin n_fail++; $display("FAIL load_tc_tick: got %b expected 1", obs_tick); end
      for (int k = 1; k <= 6; k++) begin
         drive_cycle(1'b1, 1'b1, M_RUN, 1'b0, '0, 1'b1);
         n_checks++;
         if (obs_tick !== ((k % 2) == 0)) begin
            n_fail++; $display("FAIL load_tc_after cycle %0d: got %b expected %b", k, obs_tick, (k % 2) == 0);
         end
      end
   endtask

   task automatic test_random_run();
      logic rst, en, ld;
      logic [1:0] md;
      logic [DW-1:0] val;
      int r;
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 99) != 0);
         en  = ($urandom_range(0, 9) != 0);
         r   = int'($urandom_range(0, 9));
         md  = (r < 8) ? M_RUN : ((r == 8) ? M_HALT : M_HALT2);
         ld  = ($urandom_range(0, 19) == 0);
         val = DW'($urandom_range(0, 6));
         drive_cycle(rst, en, md, ld, val, 1'b1);
         n_checks++;
         if (obs_tick !== exp_tick) begin n_fail++; $display("FAIL rand_tick cyc %0d: got %b expected %b", cyc, obs_tick, exp_tick); end
         n_checks++;
         if (tick_count !== m_cnt) begin n_fail++; $display("FAIL rand_count cyc %0d: got %0d expected %0d", cyc, tick_count, m_cnt); end
         n_checks++;
         if (div_cur !== m_div) begin n_fail++; $display("FAIL rand_div cyc %0d: got %0d expected %0d", cyc, div_cur, m_div); end
      end
   endtask

   task automatic test_step();
      logic [CW-1:0] base;
      run_n(1'b1, M_STEP, 1'b1, 14);
      base = tick_count;
      win_ticks = 0;
      run_n(1'b1, M_STEP, 1'b0, 3);
      run_n(1'b1, M_STEP, 1'b1, 20);
      n_checks++;
      if (win_ticks != 0) begin n_fail++; $display("FAIL step_glitch: got %0d ticks expected 0", win_ticks); end
      run_n(1'b1, M_STEP, 1'b0, 50);
      run_n(1'b1, M_STEP, 1'b1, 30);
      n_checks++;
      if (win_ticks != 1) begin n_fail++; $display("FAIL step_hold: got %0d ticks expected 1", win_ticks); end
      run_n(1'b1, M_STEP, 1'b0, 30);
      run_n(1'b1, M_STEP, 1'b1, 30);
      n_checks++;
      if (tick_count - base !== CW'(2)) begin n_fail++; $display("FAIL step_count: got %0d expected 2", tick_count - base); end
      m_cnt = m_cnt + CW'(2);
   endtask

   task automatic test_discard();
      win_ticks = 0;
      run_n(1'b1, M_HALT, 1'b0, 30);
      run_n(1'b1, M_STEP, 1'b0, 10);
      run_n(1'b1, M_STEP, 1'b1, 30);
      n_checks++;
      if (win_ticks != 0) begin n_fail++; $display("FAIL discard_halt: got %0d ticks expected 0", win_ticks); end
      run_n(1'b0, M_STEP, 1'b0, 30);
      run_n(1'b1, M_STEP, 1'b0, 10);
      run_n(1'b1, M_STEP, 1'b1, 30);
      n_checks++;
      if (win_ticks != 0) begin n_fail++; $display("FAIL discard_en_low: got %0d ticks expected 0", win_ticks); end
      n_checks++;
      if (tick_count !== m_cnt) begin n_fail++; $display("FAIL discard_count: got %0d expected %0d", tick_count, m_cnt); end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      run_n(1'b1, M_RUN, 1'b1, 2);
      drive_cycle(1'b1, 1'b1, M_RUN, 1'b1, DW'(3), 1'b1);
      drive_cycle(1'b1, 1'b1, M_RUN, 1'b0, '0, 1'b1);
      while (!model_tc() && guard < 10) begin
         drive_cycle(1'b1, 1'b1, M_RUN, 1'b0, '0, 1'b1);
         guard++;
      end
      drive_cycle(1'b0, 1'b1, M_STEP, 1'b0, '0, 1'b0);
      n_checks++;
      if (obs_tick !== 1'b0) begin n_fail++; $display("FAIL reset_abort_tick: got %b expected 0", obs_tick); end
      for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, M_STEP, 1'b0, '0, 1'b0);
      n_checks++;
      if (tick_count !== '0) begin n_fail++; $display("FAIL reset_mid_count: got %0d expected 0", tick_count); end
      n_checks++;
      if (div_cur !== DW'(DDIV)) begin n_fail++; $display("FAIL reset_mid_div: got %0d expected %0d", div_cur, DDIV); end
      win_ticks = 0;
      run_n(1'b1, M_STEP, 1'b0, 40);
      run_n(1'b1, M_STEP, 1'b1, 30);
      n_checks++;
      if (win_ticks != 0) begin n_fail++; $display("FAIL reset_held_press: got %0d ticks expected 0", win_ticks); end
      run_n(1'b1, M_STEP, 1'b0, 30);
      run_n(1'b1, M_STEP, 1'b1, 20);
      n_checks++;
      if (win_ticks != 1) begin n_fail++; $display("FAIL press_after_reset: got %0d ticks expected 1", win_ticks); end
      n_checks++;
      if (tick_count !== CW'(1)) begin n_fail++; $display("FAIL count_after_reset: got %0d expected 1", tick_count); end
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; mode = M_HALT; div_load = 1'b0; div_value = '0; step_btn = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_run_div4();
      test_div_zero();
      test_enable_drop();
      test_load_on_tc();
      test_random_run();
      test_step();
      test_discard();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
